// File: rtl/switch_debouncer.sv
// Per-bit switch conditioner: synchroniser chain, stability counter and registered
// level/edge outputs. Every bit runs its own independent copy of the logic.
module switch_debouncer #(
    parameter int WIDTH         = 6,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_swIn,
    output logic [WIDTH-1:0] io_swOut,
    output logic [WIDTH-1:0] io_changed,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   sync_s;
        logic                   diff_s;
        logic                   last_s;
        state_e                 state_r;
        state_e                 state_next_s;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_next_s;
        logic                   out_r;
        logic                   out_next_s;
        logic                   rise_r;
        logic                   rise_next_s;
        logic                   fall_r;
        logic                   fall_next_s;
        logic                   changed_r;
        logic                   changed_next_s;

        // Plain flop chain bringing the asynchronous switch level into the clock domain
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_r <= '0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], io_swIn[i]};
            end
        end

        assign sync_s = sync_r[SYNC_STAGES-1];
        assign diff_s = sync_s ^ out_r;
        assign last_s = (cnt_r == CNT_LAST);

        // State, counter and registered outputs
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_r   <= ST_STABLE;
                cnt_r     <= '0;
                out_r     <= 1'b0;
                rise_r    <= 1'b0;
                fall_r    <= 1'b0;
                changed_r <= 1'b0;
            end else begin
                state_r   <= state_next_s;
                cnt_r     <= cnt_next_s;
                out_r     <= out_next_s;
                rise_r    <= rise_next_s;
                fall_r    <= fall_next_s;
                changed_r <= changed_next_s;
            end
        end

        // Next state: keep counting while the level differs, drop back on match or acceptance
        always_comb begin
            state_next_s = ST_STABLE;
            cnt_next_s   = '0;
            case (state_r)
                ST_STABLE: begin
                    if (diff_s && !last_s) begin
                        state_next_s = ST_SETTLING;
                        cnt_next_s   = CNT_ONE;
                    end else begin
                        state_next_s = ST_STABLE;
                        cnt_next_s   = '0;
                    end
                end
                ST_SETTLING: begin
                    if (diff_s && !last_s) begin
                        state_next_s = ST_SETTLING;
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end else begin
                        state_next_s = ST_STABLE;
                        cnt_next_s   = '0;
                    end
                end
                default: begin
                    state_next_s = ST_STABLE;
                    cnt_next_s   = '0;
                end
            endcase
        end

        // Outputs: a level that survives the full count is accepted and pulses once
        always_comb begin
            out_next_s     = out_r;
            rise_next_s    = 1'b0;
            fall_next_s    = 1'b0;
            changed_next_s = 1'b0;
            if (diff_s && last_s) begin
                out_next_s     = sync_s;
                rise_next_s    = sync_s;
                fall_next_s    = ~sync_s;
                changed_next_s = 1'b1;
            end else begin
                out_next_s     = out_r;
                rise_next_s    = 1'b0;
                fall_next_s    = 1'b0;
                changed_next_s = 1'b0;
            end
        end

        assign io_swOut[i]   = out_r;
        assign io_rise[i]    = rise_r;
        assign io_fall[i]    = fall_r;
        assign io_changed[i] = changed_r;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the switch-to-LED logic block and drives its switch inputs.
- Synchronises raw, asynchronous board switch levels into the clock domain.
- Filters contact bounce per bit and presents clean, stable switch levels.
- Emits one-cycle change pulses per bit so downstream logic can detect transitions.

Parameters:
- WIDTH, 6, number of independent switch bits (default covers three 2-bit switch pairs).
- SYNC_STAGES, 2, flip-flop stages in each bit's synchroniser chain; legal range ≥2.
- STABLE_CYCLES, 1000, consecutive clock cycles a synchronised level must hold before it is accepted; legal range ≥1.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset); assertion takes effect immediately, deassertion is sampled by clock.
- io_swIn  input  WIDTH  raw switch levels, asynchronous to clock.
- io_swOut  output  WIDTH  debounced switch levels; feeds the downstream logic block's switch inputs.
- io_changed  output  WIDTH  one-cycle pulse per bit, asserted in the cycle io_swOut[i] takes a new value.
- io_rise  output  WIDTH  one-cycle pulse per bit, asserted when io_swOut[i] goes 0→1.
- io_fall  output  WIDTH  one-cycle pulse per bit, asserted when io_swOut[i] goes 1→0.

Behaviour:
- Bits are fully independent; each bit has its own synchroniser chain, counter and state. No interaction between bits.
- Reset (reset=0): all synchroniser flops, io_swOut, counters, io_changed, io_rise and io_fall go to 0 immediately.
  - Reset asserted mid-settle discards the count.
  - After release, bits whose io_swIn is 1 are treated as a new change and settle normally (they reach 1 after the full latency).
- Synchroniser: s[i] is the output of a SYNC_STAGES-deep flop chain on io_swIn[i]. No logic between the chain stages.
- Per-bit state machine:
  - STABLE: s[i]==io_swOut[i]; counter held at 0.
  - SETTLING: entered on the first cycle s[i]!=io_swOut[i]; counter increments by 1 every cycle that s[i]!=io_swOut[i] persists.
  - SETTLING→STABLE (glitch rejected): s[i] returns equal to io_swOut[i] before acceptance; counter clears to 0 and io_swOut is unchanged.
  - SETTLING→STABLE (accepted): counter==STABLE_CYCLES-1 and s[i]!=io_swOut[i]; at the next edge io_swOut[i]<=s[i] and the counter clears.
- Counter width: clog2(STABLE_CYCLES+1) bits. It never exceeds STABLE_CYCLES-1 and never wraps.
- Latency: a clean level change on io_swIn reaches io_swOut exactly SYNC_STAGES+STABLE_CYCLES rising edges later.
  - STABLE_CYCLES=1 degenerates to a pure synchroniser with one extra register stage.
- Pulses:
  - io_changed, io_rise and io_fall are registered, 0 by default.
  - They are asserted for exactly the one cycle in which the new io_swOut value is first visible.
  - io_rise and io_fall are mutually exclusive, and io_changed = io_rise | io_fall.
  - No pulse is produced for a rejected glitch.
- Continuous bounce faster than STABLE_CYCLES: io_swOut holds its last accepted value indefinitely.
- All outputs come directly from flops; there is no combinational path from io_swIn to any output.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, WIDTH=6):
- Reset with io_swIn=6'h3F, release at cycle 0, hold input → io_swOut=0 through cycle 5, io_swOut=6'h3F at cycle 6; io_changed and io_rise =6'h3F for cycle 6 only.
- Bit0 clean 0→1, held → io_swOut[0]=1 exactly 6 edges later, one io_rise[0] pulse, io_fall=0 throughout, other bits unchanged.
- Bit2 bounces 1-0-1-0 at 1-cycle spacing, then settles to 1 → no pulse during bounce; io_swOut[2]=1 six edges after the final stable 1.
- Bit3 high for 3 cycles, then low (glitch shorter than STABLE_CYCLES) → io_swOut[3] stays 0 and io_changed[3] never asserts.
- Bits 1 and 4 change simultaneously, 0→1 and 1→0 → both update on the same cycle; io_rise=6'h02 and io_fall=6'h10 for one cycle.
- reset asserted 2 cycles into a settle → outputs go to 0 asynchronously; after release, with input still high, the full 6-edge latency is re-counted from the release.
